online_div_sequencer: RTL and testbench

Iteration sequencer for the radix-2 signed-digit online divider. Accepts the dividend/divisor digit streams MSD-first through a valid/ready handshake, runs N_DIGITS+DELTA iterations, and drives the datapath strobes: init, load (CA-REG append), and select (SELD/residue commit). It then returns the quotient digits through a second valid/ready handshake. It sits between the digit-serial source/sink and the CA_REG/SDVM/V-block datapath, replacing free-running counter control.

---
 rtl/online_div_sequencer_if.sv | 22 ++
 rtl/online_div_sequencer.sv | 163 ++++++++++++++++
 tb/tb_online_div_sequencer.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/online_div_sequencer_if.sv
// Digit-stream handshakes of the online divider sequencer: operand pairs in, quotient digits out.
interface online_div_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] x_digit_in;
    logic [1:0] d_digit_in;
    logic       q_valid;
    logic       q_ready;
    logic [1:0] q_digit;

    // Digit source/sink side
    modport master (
        output in_valid, x_digit_in, d_digit_in, q_ready,
        input  in_ready, q_valid, q_digit
    );

    // Sequencer side
    modport slave (
        input  in_valid, x_digit_in, d_digit_in, q_ready,
        output in_ready, q_valid, q_digit
    );
endinterface

// File: rtl/online_div_sequencer.sv
// Iteration sequencer for the radix-2 signed-digit online divider.
// Runs N_DIGITS+DELTA LOAD/SEL iterations, strobes the datapath and
// streams the quotient digits out with back-pressure.
module online_div_sequencer #(
    parameter int unsigned N_DIGITS = 8,
    parameter int unsigned DELTA    = 3,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    online_div_sequencer_if.slave io,
    output logic                  dp_init,
    output logic                  dp_load,
    output logic                  dp_sel,
    output logic                  dp_qzero,
    output logic [CNT_W-1:0]      dp_iter,
    output logic [1:0]            dp_x_digit,
    output logic [1:0]            dp_d_digit,
    input  logic [1:0]            dp_q_digit,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned      LAST_K   = N_DIGITS + DELTA - 1;
    localparam logic [CNT_W-1:0] K_NDIG   = CNT_W'(N_DIGITS);
    localparam logic [CNT_W-1:0] K_DELTA  = CNT_W'(DELTA);
    localparam logic [CNT_W-1:0] K_LAST   = CNT_W'(LAST_K);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(N_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_SEL
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [CNT_W-1:0] ocnt_q, ocnt_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             q_valid_q, q_valid_d;
    logic [1:0]       q_digit_q, q_digit_d;

    // The 11 code has no signed-digit meaning; it is forwarded as zero
    function automatic logic [1:0] legal_digit(input logic [1:0] dig);
        return (dig == 2'b11) ? 2'b00 : dig;
    endfunction

    // Next-state, strobe and output-stream logic
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        ocnt_d     = ocnt_q;
        busy_d     = busy_q;
        err_d      = err_q;
        q_valid_d  = q_valid_q;
        q_digit_d  = q_digit_q;
        io.in_ready = 1'b0;
        dp_init    = 1'b0;
        dp_load    = 1'b0;
        dp_sel     = 1'b0;
        dp_qzero   = 1'b0;
        dp_x_digit = 2'b00;
        dp_d_digit = 2'b00;
        done       = 1'b0;

        // Output transfer; the last digit ends the division
        if (q_valid_q && io.q_ready) begin
            q_valid_d = 1'b0;
            ocnt_d    = ocnt_q + CNT_W'(1);
            if (ocnt_q == OUT_LAST) begin
                done   = 1'b1;
                busy_d = 1'b0;
                ocnt_d = '0;
            end
        end

        case (state_q)
            S_IDLE: begin
                // busy stays high here until the final digit drains
                if (start && !busy_q) begin
                    state_d = S_INIT;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
            S_INIT: begin
                dp_init = 1'b1;
                k_d     = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (k_q < K_NDIG) begin
                    io.in_ready = 1'b1;
                    if (io.in_valid) begin
                        dp_load    = 1'b1;
                        dp_x_digit = legal_digit(io.x_digit_in);
                        dp_d_digit = legal_digit(io.d_digit_in);
                        if (io.x_digit_in == 2'b11 || io.d_digit_in == 2'b11) begin
                            err_d = 1'b1;
                        end
                        state_d = S_SEL;
                    end
                end else begin
                    // Flush: operands are exhausted, append zeros
                    dp_load = 1'b1;
                    state_d = S_SEL;
                end
            end
            S_SEL: begin
                if (k_q < K_DELTA) begin
                    // Online delay: digit forced to zero and not emitted
                    dp_sel   = 1'b1;
                    dp_qzero = 1'b1;
                    k_d      = k_q + CNT_W'(1);
                    state_d  = S_LOAD;
                end else if (!q_valid_q || io.q_ready) begin
                    dp_sel    = 1'b1;
                    q_digit_d = dp_q_digit;
                    q_valid_d = 1'b1;
                    if (k_q == K_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        k_d     = k_q + CNT_W'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            ocnt_q    <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            q_valid_q <= 1'b0;
            q_digit_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            ocnt_q    <= ocnt_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            q_valid_q <= q_valid_d;
            q_digit_q <= q_digit_d;
        end
    end

    assign busy       = busy_q;
    assign err        = err_q;
    assign dp_iter    = k_q;
    assign io.q_valid = q_valid_q;
    assign io.q_digit = q_digit_q;

endmodule

// File: tb/tb_online_div_sequencer.sv
// Self-checking bench for online_div_sequencer: cycle timelines of the
// datapath strobes plus a scoreboard of the emitted quotient digits.
module tb_online_div_sequencer;

    localparam int unsigned N_DIGITS = 8;
    localparam int unsigned DELTA    = 3;
    localparam int unsigned CNT_W    = 4;
    localparam int          ND       = 8;
    localparam int          DL       = 3;
    localparam int          N_ITER   = 11;
    localparam int          MAX_CYC  = 200;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             busy;
    logic             dp_init, dp_load, dp_sel, dp_qzero;
    logic [CNT_W-1:0] dp_iter;
    logic [1:0]       dp_x_digit, dp_d_digit, dp_q_digit;
    logic             done, err;

    online_div_sequencer_if io ();

    online_div_sequencer #(
        .N_DIGITS (N_DIGITS),
        .DELTA    (DELTA),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .io         (io),
        .dp_init    (dp_init),
        .dp_load    (dp_load),
        .dp_sel     (dp_sel),
        .dp_qzero   (dp_qzero),
        .dp_iter    (dp_iter),
        .dp_x_digit (dp_x_digit),
        .dp_d_digit (dp_d_digit),
        .dp_q_digit (dp_q_digit),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Stimulus tables and a stand-in datapath digit per iteration
    logic [1:0] x_tab [0:15];
    logic [1:0] d_tab [0:15];
    logic [1:0] q_tab [0:15];
    assign dp_q_digit = q_tab[dp_iter];

    // Scoreboard and event logs (cycle numbers relative to the start cycle)
    logic [1:0] exp_q [$];
    int         init_log [$];
    int         load_cyc [$];
    int         load_k   [$];
    logic [1:0] load_x   [$];
    logic [1:0] load_d   [$];
    logic       load_rdy [$];
    int         sel_cyc  [$];
    int         sel_k    [$];
    logic       sel_qz   [$];
    int         xfer_cyc [$];
    int         done_cyc [$];
    logic       busy_log [0:255];
    logic       err_log  [0:255];
    int         t0 = 0;
    logic       mon_en = 1'b0;
    logic       hold_pending = 1'b0;
    logic [1:0] hold_digit = 2'b00;

    // Run configuration
    int in_lo_at, in_lo_len, qr_lo_at, qr_lo_len, rst_at, sa, sb, tail;

    // Per-cycle monitor: logs strobes, checks exclusivity, hold and scoreboard
    always @(negedge clk) begin : monitor
        logic [1:0] e;
        int         n;
        if (mon_en) begin
            if (dp_init) init_log.push_back(cyc - t0);
            if (dp_load) begin
                load_cyc.push_back(cyc - t0);
                load_k.push_back(int'(dp_iter));
                load_x.push_back(dp_x_digit);
                load_d.push_back(dp_d_digit);
                load_rdy.push_back(io.in_ready);
            end
            if (dp_sel) begin
                sel_cyc.push_back(cyc - t0);
                sel_k.push_back(int'(dp_iter));
                sel_qz.push_back(dp_qzero);
            end
            if (done) done_cyc.push_back(cyc - t0);
            if (dp_init || dp_load || dp_sel) begin
                n = int'(dp_init) + int'(dp_load) + int'(dp_sel);
                checks++;
                if (n != 1) begin
                    errors++;
                    $display("FAIL strobe_excl cycle %0d got %0d strobes exp 1", cyc - t0, n);
                end
            end
            if (hold_pending) begin
                checks++;
                if (io.q_valid !== 1'b1 || io.q_digit !== hold_digit) begin
                    errors++;
                    $display("FAIL q_hold cycle %0d got v=%b d=%b exp v=1 d=%b",
                             cyc - t0, io.q_valid, io.q_digit, hold_digit);
                end
            end
            hold_pending = io.q_valid && !io.q_ready;
            hold_digit   = io.q_digit;
            if (io.q_valid && io.q_ready) begin
                xfer_cyc.push_back(cyc - t0);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL q_extra cycle %0d got digit %b exp no transfer", cyc - t0, io.q_digit);
                end else begin
                    e = exp_q.pop_front();
                    if (io.q_digit !== e) begin
                        errors++;
                        $display("FAIL q_digit cycle %0d got %b exp %b", cyc - t0, io.q_digit, e);
                    end
                end
            end
        end
    end

    function automatic logic [1:0] rand_dig();
        case ($urandom_range(0, 2))
            0:       return 2'b00;
            1:       return 2'b10;
            default: return 2'b01;
        endcase
    endfunction

    task automatic fill_tabs(input bit rnd);
        for (int i = 0; i < 16; i++) begin
            x_tab[i] = rnd ? rand_dig() : ((i == 0) ? 2'b10 : 2'b00);
            d_tab[i] = rnd ? rand_dig() : ((i < 2) ? 2'b10 : 2'b00);
            q_tab[i] = rand_dig();
        end
    endtask

    task automatic default_cfg();
        in_lo_at = -1; in_lo_len = 0;
        qr_lo_at = -1; qr_lo_len = 0;
        rst_at = -1; sa = -1; sb = -1; tail = 1;
    endtask

    // Drives one division; returns with the bench at the start of the stop cycle
    task automatic run_div(output int done_at);
        int idx;
        int stop;
        bit reached;
        idx = 0; done_at = -1; stop = -1; reached = 1'b0;
        @(posedge clk); #1;
        init_log.delete(); load_cyc.delete(); load_k.delete(); load_x.delete();
        load_d.delete(); load_rdy.delete(); sel_cyc.delete(); sel_k.delete();
        sel_qz.delete(); xfer_cyc.delete(); done_cyc.delete();
        hold_pending = 1'b0;
        t0 = cyc;
        for (int k = DL; k < N_ITER; k++) exp_q.push_back(q_tab[k]);
        for (int c = 0; c < MAX_CYC; c++) begin
            start       = (c == 0) || (c == sa) || (c == sb);
            rst_n       = (c != rst_at);
            io.in_valid = !((c >= in_lo_at) && (c < in_lo_at + in_lo_len));
            if (idx < ND) begin
                io.x_digit_in = x_tab[idx];
                io.d_digit_in = d_tab[idx];
            end else begin
                io.x_digit_in = 2'b10;
                io.d_digit_in = 2'b01;
            end
            io.q_ready = !((c >= qr_lo_at) && (c < qr_lo_at + qr_lo_len));
            @(negedge clk);
            busy_log[c] = busy;
            err_log[c]  = err;
            if (io.in_valid && io.in_ready) idx++;
            if (done && done_at < 0) begin
                done_at = c;
                stop    = c + tail;
            end
            if (c == rst_at) stop = c + 1;
            @(posedge clk); #1;
            if (stop >= 0 && c + 1 >= stop) begin
                reached = 1'b1;
                break;
            end
        end
        start       = 1'b0;
        io.in_valid = 1'b0;
        io.q_ready  = 1'b1;
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL run_timeout got no end within %0d cycles exp done", MAX_CYC);
        end
    endtask

    task automatic test_reset();
        logic [18:0] v;
        rst_n = 1'b0; start = 1'b0;
        io.in_valid = 1'b0; io.x_digit_in = 2'b00; io.d_digit_in = 2'b00; io.q_ready = 1'b0;
        fill_tabs(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        v = {busy, io.in_ready, dp_init, dp_load, dp_sel, dp_qzero, dp_iter,
             dp_x_digit, dp_d_digit, io.q_valid, io.q_digit, done, err};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp all zero", v);
        end
        rst_n = 1'b1; io.q_ready = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        int da;
        logic [1:0] ex;
        fill_tabs(1'b0);
        default_cfg();
        run_div(da);
        @(negedge clk);
        checks++;
        if (init_log.size() != 1 || init_log[0] != 1) begin
            errors++; $display("FAIL basic_init got %0d inits first %0d exp one at 1", init_log.size(), init_log[0]);
        end
        checks++;
        if (load_cyc.size() != N_ITER) begin
            errors++; $display("FAIL basic_load_count got %0d exp %0d", load_cyc.size(), N_ITER);
        end
        for (int k = 0; k < N_ITER && k < load_cyc.size(); k++) begin
            ex = (k < ND) ? x_tab[k] : 2'b00;
            checks++;
            if (load_cyc[k] != 2 + 2 * k || load_k[k] != k || load_x[k] !== ex
                || load_d[k] !== ((k < ND) ? d_tab[k] : 2'b00) || load_rdy[k] !== (k < ND)) begin
                errors++;
                $display("FAIL basic_load k=%0d got c=%0d it=%0d x=%b d=%b rdy=%b exp c=%0d x=%b",
                         k, load_cyc[k], load_k[k], load_x[k], load_d[k], load_rdy[k], 2 + 2 * k, ex);
            end
        end
        checks++;
        if (sel_cyc.size() != N_ITER) begin
            errors++; $display("FAIL basic_sel_count got %0d exp %0d", sel_cyc.size(), N_ITER);
        end
        for (int k = 0; k < N_ITER && k < sel_cyc.size(); k++) begin
            checks++;
            if (sel_cyc[k] != 3 + 2 * k || sel_k[k] != k || sel_qz[k] !== (k < DL)) begin
                errors++;
                $display("FAIL basic_sel k=%0d got c=%0d it=%0d qz=%b exp c=%0d qz=%b",
                         k, sel_cyc[k], sel_k[k], sel_qz[k], 3 + 2 * k, (k < DL));
            end
        end
        checks++;
        if (xfer_cyc.size() != ND) begin
            errors++; $display("FAIL basic_xfer_count got %0d exp %0d", xfer_cyc.size(), ND);
        end
        for (int j = 0; j < ND && j < xfer_cyc.size(); j++) begin
            checks++;
            if (xfer_cyc[j] != 10 + 2 * j) begin
                errors++; $display("FAIL basic_xfer j=%0d got %0d exp %0d", j, xfer_cyc[j], 10 + 2 * j);
            end
        end
        checks++;
        if (da != 24 || done_cyc.size() != 1) begin
            errors++; $display("FAIL basic_done got %0d (%0d pulses) exp 24", da, done_cyc.size());
        end
        checks++;
        if (busy_log[0] !== 1'b0 || busy_log[1] !== 1'b1 || busy_log[24] !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy got c0=%b c1=%b c24=%b c25=%b exp 0110",
                     busy_log[0], busy_log[1], busy_log[24], busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL basic_sb_left got %0d exp 0", exp_q.size());
        end
    endtask

    task automatic test_in_stall();
        int da;
        int e;
        fill_tabs(1'b1);
        default_cfg();
        in_lo_at = 6; in_lo_len = 5;
        run_div(da);
        checks++;
        if (load_cyc.size() != N_ITER) begin
            errors++; $display("FAIL install_load_count got %0d exp %0d", load_cyc.size(), N_ITER);
        end
        for (int k = 0; k < N_ITER && k < load_cyc.size(); k++) begin
            e = 2 + 2 * k + ((k >= 2) ? 5 : 0);
            checks++;
            if (load_cyc[k] != e || load_x[k] !== ((k < ND) ? x_tab[k] : 2'b00)
                || load_d[k] !== ((k < ND) ? d_tab[k] : 2'b00)) begin
                errors++;
                $display("FAIL install_load k=%0d got c=%0d x=%b d=%b exp c=%0d", k, load_cyc[k], load_x[k], load_d[k], e);
            end
        end
        for (int j = 0; j < ND && j < xfer_cyc.size(); j++) begin
            checks++;
            if (xfer_cyc[j] != 15 + 2 * j) begin
                errors++; $display("FAIL install_xfer j=%0d got %0d exp %0d", j, xfer_cyc[j], 15 + 2 * j);
            end
        end
        checks++;
        if (da != 29 || xfer_cyc.size() != ND || exp_q.size() != 0) begin
            errors++; $display("FAIL install_done got %0d xfers %0d exp 29 with %0d", da, xfer_cyc.size(), ND);
        end
    endtask

    task automatic test_q_stall();
        int da;
        int e;
        fill_tabs(1'b1);
        default_cfg();
        // q_ready low at 10 costs nothing: the k=4 SEL is not reached until 11
        qr_lo_at = 10; qr_lo_len = 4;
        run_div(da);
        checks++;
        if (sel_cyc.size() != N_ITER) begin
            errors++; $display("FAIL qstall_sel_count got %0d exp %0d", sel_cyc.size(), N_ITER);
        end
        for (int k = 0; k < N_ITER && k < sel_cyc.size(); k++) begin
            e = (k < 4) ? 3 + 2 * k : 6 + 2 * k;
            checks++;
            if (sel_cyc[k] != e) begin
                errors++; $display("FAIL qstall_sel k=%0d got %0d exp %0d", k, sel_cyc[k], e);
            end
        end
        checks++;
        if (xfer_cyc.size() != ND) begin
            errors++; $display("FAIL qstall_xfer_count got %0d exp %0d", xfer_cyc.size(), ND);
        end
        for (int j = 0; j < ND && j < xfer_cyc.size(); j++) begin
            e = (j == 0) ? 14 : ((j == 1) ? 15 : 13 + 2 * j);
            checks++;
            if (xfer_cyc[j] != e) begin
                errors++; $display("FAIL qstall_xfer j=%0d got %0d exp %0d", j, xfer_cyc[j], e);
            end
        end
        checks++;
        if (da != 27 || exp_q.size() != 0) begin
            errors++; $display("FAIL qstall_done got %0d left %0d exp 27 left 0", da, exp_q.size());
        end
    endtask

    task automatic test_illegal();
        int da;
        fill_tabs(1'b0);
        x_tab[1] = 2'b11;
        d_tab[5] = 2'b11;
        default_cfg();
        run_div(da);
        @(negedge clk);
        checks++;
        if (load_x.size() != N_ITER || load_x[1] !== 2'b00 || load_d[1] !== 2'b10) begin
            errors++; $display("FAIL illegal_x got x=%b d=%b exp x=00 d=10", load_x[1], load_d[1]);
        end
        checks++;
        if (load_d.size() != N_ITER || load_d[5] !== 2'b00) begin
            errors++; $display("FAIL illegal_d got %b exp 00", load_d[5]);
        end
        checks++;
        if (err_log[0] !== 1'b0 || err_log[4] !== 1'b0 || err_log[5] !== 1'b1) begin
            errors++; $display("FAIL illegal_err_set got c0=%b c4=%b c5=%b exp 0 0 1", err_log[0], err_log[4], err_log[5]);
        end
        checks++;
        if (da != 24 || err_log[24] !== 1'b1 || err !== 1'b1) begin
            errors++; $display("FAIL illegal_err_sticky got done=%0d c24=%b c25=%b exp 24 1 1", da, err_log[24], err);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL illegal_sb_left got %0d exp 0", exp_q.size());
        end
    endtask

    task automatic test_busy_start_flush();
        int da;
        fill_tabs(1'b1);
        default_cfg();
        sa = 5; sb = 24; tail = 4;
        run_div(da);
        @(negedge clk);
        checks++;
        if (err_log[0] !== 1'b1 || err_log[1] !== 1'b0) begin
            errors++; $display("FAIL err_clear got c0=%b c1=%b exp 1 0", err_log[0], err_log[1]);
        end
        checks++;
        if (init_log.size() != 1 || done_cyc.size() != 1 || da != 24) begin
            errors++;
            $display("FAIL busy_start got %0d inits %0d dones done=%0d exp 1 1 24", init_log.size(), done_cyc.size(), da);
        end
        for (int k = ND; k < N_ITER && k < load_cyc.size(); k++) begin
            checks++;
            if (load_rdy[k] !== 1'b0 || load_x[k] !== 2'b00 || load_d[k] !== 2'b00 || load_k[k] != k) begin
                errors++;
                $display("FAIL flush k=%0d got rdy=%b x=%b d=%b it=%0d exp 0 00 00", k, load_rdy[k], load_x[k], load_d[k], load_k[k]);
            end
        end
        checks++;
        if (load_cyc.size() != N_ITER || busy !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL flush_end got loads=%0d busy=%b left=%0d exp 11 0 0", load_cyc.size(), busy, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int da;
        logic [18:0] v;
        fill_tabs(1'b1);
        default_cfg();
        rst_at = 12;
        run_div(da);
        rst_n = 1'b1;
        @(negedge clk);
        v = {busy, io.in_ready, dp_init, dp_load, dp_sel, dp_qzero, dp_iter,
             dp_x_digit, dp_d_digit, io.q_valid, io.q_digit, done, err};
        checks++;
        if (v !== '0) begin
            errors++; $display("FAIL midreset_outputs got %b exp all zero", v);
        end
        checks++;
        if (xfer_cyc.size() != 2 || da != -1) begin
            errors++; $display("FAIL midreset_xfers got %0d done=%0d exp 2 -1", xfer_cyc.size(), da);
        end
        exp_q.delete();
        fill_tabs(1'b1);
        default_cfg();
        run_div(da);
        @(negedge clk);
        checks++;
        if (init_log.size() != 1 || init_log[0] != 1) begin
            errors++; $display("FAIL restart_init got %0d inits exp one at 1", init_log.size());
        end
        checks++;
        if (da != 24 || xfer_cyc.size() != ND || exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_done got done=%0d xfers=%0d left=%0d busy=%b exp 24 8 0 0", da, xfer_cyc.size(), exp_q.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_in_stall();
        test_q_stall();
        test_illegal();
        test_busy_start_flush();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
